// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor front end.
// INERT_FAST_SIM_EN shortens the power-up wait to a 4-bit counter.
package inert_pkg;

`ifdef INERT_FAST_SIM_EN
    localparam int PWR_CNT_W_DFLT = 4;
`else
    localparam int PWR_CNT_W_DFLT = 16;
`endif

    typedef enum logic [3:0] {
        WAIT_PWR,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        DONE
    } inert_state_t;

    // Sensor configuration writes, issued once after power-up
    localparam logic [15:0] CMD_INIT1 = 16'h0D02;
    localparam logic [15:0] CMD_INIT2 = 16'h1053;
    localparam logic [15:0] CMD_INIT3 = 16'h1150;
    localparam logic [15:0] CMD_INIT4 = 16'h1460;

    // Register reads: bit 15 set selects read, low byte is don't-care
    localparam logic [15:0] CMD_RD_PL = 16'hA200;
    localparam logic [15:0] CMD_RD_PH = 16'hA300;
    localparam logic [15:0] CMD_RD_AL = 16'hAC00;
    localparam logic [15:0] CMD_RD_AH = 16'hAD00;

    localparam int BYTE_PL = 0;
    localparam int BYTE_PH = 1;
    localparam int BYTE_AL = 2;
    localparam int BYTE_AH = 3;

endpackage

// File: rtl/inert_intf_if.sv
// Pin-level bundle between the inertial front end and the sensor / consumer.
interface inert_intf_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        INT;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    modport master (
        input  MISO, INT,
        output SS_n, SCLK, MOSI, vld, ptch_rt, AZ
    );

    modport slave (
        output MISO, INT,
        input  SS_n, SCLK, MOSI, vld, ptch_rt, AZ
    );
endinterface

// File: rtl/inert_intf_spi_mnrch.sv
// 16-bit mode-3 SPI master: MOSI shifts on SCLK fall, MISO sampled on SCLK rise.
module spi_mnrch #(
    parameter int SCLK_DIV_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam logic [SCLK_DIV_W-1:0] DIV_ONE     = {{(SCLK_DIV_W-1){1'b0}}, 1'b1};
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE_M1 = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_FALL_M1 = '1;

    logic                  busy_reg;
    logic                  ss_n_reg;
    logic                  done_reg;
    logic                  miso_smpl_reg;
    logic [SCLK_DIV_W-1:0] div_reg;
    logic [3:0]            bit_cnt_reg;
    logic [15:0]           shft_reg;

    // SCLK low for the first half of each period, so SS_n fall doubles as the first fall
    assign SCLK    = div_reg[SCLK_DIV_W-1] | ~busy_reg;
    assign MOSI    = busy_reg & shft_reg[15];
    assign SS_n    = ss_n_reg;
    assign done    = done_reg;
    assign rd_data = shft_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg      <= 1'b0;
            ss_n_reg      <= 1'b1;
            done_reg      <= 1'b0;
            miso_smpl_reg <= 1'b0;
            div_reg       <= '0;
            bit_cnt_reg   <= '0;
            shft_reg      <= '0;
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg) begin
                if (wrt) begin
                    busy_reg    <= 1'b1;
                    ss_n_reg    <= 1'b0;
                    div_reg     <= '0;
                    bit_cnt_reg <= '0;
                    shft_reg    <= cmd;
                end
            end else begin
                div_reg <= div_reg + DIV_ONE;
                if (div_reg == DIV_RISE_M1) begin
                    miso_smpl_reg <= MISO;
                end
                // The 16th fall position is where SS_n is released instead
                if (div_reg == DIV_FALL_M1) begin
                    shft_reg    <= {shft_reg[14:0], miso_smpl_reg};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd15) begin
                        busy_reg <= 1'b0;
                        ss_n_reg <= 1'b1;
                        done_reg <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/inert_intf.sv
// Inertial sensor front end: power-up wait, sensor init, INT-triggered pitch/AZ reads.
// PWR_CNT_W defaults to 16, or 4 when INERT_FAST_SIM_EN is defined.
module inert_intf
    import inert_pkg::*;
#(
    parameter int SCLK_DIV_W = 4,
    parameter int PWR_CNT_W  = PWR_CNT_W_DFLT
) (
    input  logic            clk,
    input  logic            rst_n,
    inert_intf_if.master    bus
);

    localparam logic [PWR_CNT_W-1:0] PWR_ONE = {{(PWR_CNT_W-1){1'b0}}, 1'b1};

    inert_state_t         state_reg, state_next;
    logic [PWR_CNT_W-1:0] pwr_cnt_reg;
    logic                 int_meta_reg, int_sync_reg;
    logic [7:0]           byte_reg [4];
    logic [15:0]          ptch_reg, az_reg;
    logic                 vld_reg;

    logic                 wrt;
    logic [15:0]          cmd;
    logic                 done;
    logic [15:0]          rd_data;
    logic [7:0]           rd_lo;
    logic [7:0]           rd_hi_unused;
    logic [3:0]           cap;
    logic                 upd;
    logic                 pwr_done;

    assign rd_lo        = rd_data[7:0];
    assign rd_hi_unused = rd_data[15:8];
    assign pwr_done     = &pwr_cnt_reg;

    spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (bus.SS_n),
        .SCLK    (bus.SCLK),
        .MOSI    (bus.MOSI),
        .MISO    (bus.MISO)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta_reg <= 1'b0;
            int_sync_reg <= 1'b0;
        end else begin
            int_meta_reg <= bus.INT;
            int_sync_reg <= int_meta_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwr_cnt_reg <= '0;
        end else if (state_reg == WAIT_PWR && !pwr_done) begin
            pwr_cnt_reg <= pwr_cnt_reg + PWR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= WAIT_PWR;
        end else begin
            state_reg <= state_next;
        end
    end

    // Each transfer is launched on the transition into the state that waits for its done
    always_comb begin
        state_next = state_reg;
        wrt        = 1'b0;
        cmd        = '0;
        cap        = '0;
        upd        = 1'b0;
        unique case (state_reg)
            WAIT_PWR: if (pwr_done) begin
                wrt = 1'b1; cmd = CMD_INIT1; state_next = INIT1;
            end
            INIT1: if (done) begin
                wrt = 1'b1; cmd = CMD_INIT2; state_next = INIT2;
            end
            INIT2: if (done) begin
                wrt = 1'b1; cmd = CMD_INIT3; state_next = INIT3;
            end
            INIT3: if (done) begin
                wrt = 1'b1; cmd = CMD_INIT4; state_next = INIT4;
            end
            INIT4: if (done) begin
                state_next = IDLE;
            end
            IDLE: if (int_sync_reg) begin
                wrt = 1'b1; cmd = CMD_RD_PL; state_next = RD_PL;
            end
            RD_PL: if (done) begin
                cap[BYTE_PL] = 1'b1; wrt = 1'b1; cmd = CMD_RD_PH; state_next = RD_PH;
            end
            RD_PH: if (done) begin
                cap[BYTE_PH] = 1'b1; wrt = 1'b1; cmd = CMD_RD_AL; state_next = RD_AL;
            end
            RD_AL: if (done) begin
                cap[BYTE_AL] = 1'b1; wrt = 1'b1; cmd = CMD_RD_AH; state_next = RD_AH;
            end
            RD_AH: if (done) begin
                cap[BYTE_AH] = 1'b1; state_next = DONE;
            end
            DONE: begin
                upd = 1'b1; state_next = IDLE;
            end
            default: state_next = WAIT_PWR;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hold
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    byte_reg[gi] <= '0;
                end else if (cap[gi]) begin
                    byte_reg[gi] <= rd_lo;
                end
            end
        end
    endgenerate

    // Outputs move only as a complete pair, on the same edge vld rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg  <= 1'b0;
            ptch_reg <= '0;
            az_reg   <= '0;
        end else begin
            vld_reg <= upd;
            if (upd) begin
                ptch_reg <= {byte_reg[BYTE_PH], byte_reg[BYTE_PL]};
                az_reg   <= {byte_reg[BYTE_AH], byte_reg[BYTE_AL]};
            end
        end
    end

    assign bus.vld     = vld_reg;
    assign bus.ptch_rt = ptch_reg;
    assign bus.AZ      = az_reg;

endmodule

// File: tb/tb_inert_intf.sv
// Bench for inert_intf: sensor model on the SPI pins plus a scoreboard on vld/ptch_rt/AZ.
module tb_inert_intf;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    inert_intf_if bus ();

    inert_intf #(.SCLK_DIV_W(4), .PWR_CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int xfer_starts = 0;
    int last_ah_cyc = -100;

    logic [15:0] exp_cmd_q [$];
    logic [7:0]  resp_q    [$];
    logic [31:0] exp_out_q [$];
    logic [15:0] last_pt = '0;
    logic [15:0] last_az = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected by the model", name);
    endtask

    task automatic push_init();
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1053);
        exp_cmd_q.push_back(16'h1150);
        exp_cmd_q.push_back(16'h1460);
    endtask

    // One read sequence: the sensor hands out pl, ph, al, ah in that order
    task automatic push_seq(input logic [7:0] pl, input logic [7:0] ph,
                            input logic [7:0] al, input logic [7:0] ah);
        exp_cmd_q.push_back(16'hA200);
        exp_cmd_q.push_back(16'hA300);
        exp_cmd_q.push_back(16'hAC00);
        exp_cmd_q.push_back(16'hAD00);
        resp_q.push_back(pl);
        resp_q.push_back(ph);
        resp_q.push_back(al);
        resp_q.push_back(ah);
        exp_out_q.push_back({ph, pl, ah, al});
    endtask

    task automatic push_rand_seq();
        push_seq(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_cmd_q.size() != 0 || exp_out_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < budget), 1'b1);
    endtask

    task automatic wait_starts(input string name, input int target, input int budget);
        int n = 0;
        while (xfer_starts < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, (n < budget), 1'b1);
    endtask

    // INT pulse with a phase unrelated to clk
    task automatic int_pulse(input int width_clk);
        @(posedge clk);
        #($urandom_range(1, 9));
        bus.INT = 1'b1;
        #(10 * width_clk);
        bus.INT = 1'b0;
    endtask

    task automatic wait_first_ss(input string name);
        int n = 0;
        while (bus.SS_n && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, (n >= 15 && n <= 20), 1'b1);
    endtask

    // Sensor model: shifts MISO on SCLK fall, captures MOSI on SCLK rise
    initial begin
        logic        prev_ss = 1'b1;
        logic        prev_sclk = 1'b1;
        int          nrise = 0;
        int          oidx = 15;
        logic [15:0] mosi_w = '0;
        logic [15:0] miso_w = '0;
        logic [15:0] exp_w;
        bus.MISO = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_ss && !bus.SS_n) begin
                nrise  = 0;
                oidx   = 15;
                mosi_w = '0;
                miso_w = {8'($urandom), 8'h00};
                bus.MISO = miso_w[15];
                xfer_starts++;
            end else if (!bus.SS_n) begin
                if (!prev_sclk && bus.SCLK) begin
                    mosi_w = {mosi_w[14:0], bus.MOSI};
                    nrise++;
                    if (nrise == 8 && mosi_w[7]) begin
                        if (resp_q.size() == 0) begin
                            fail_now("resp_underflow");
                            miso_w[7:0] = 8'h00;
                        end else begin
                            miso_w[7:0] = resp_q.pop_front();
                        end
                    end
                end else if (prev_sclk && !bus.SCLK) begin
                    if (oidx > 0) oidx--;
                    bus.MISO = miso_w[oidx];
                end
            end else if (!prev_ss && bus.SS_n && rst_n) begin
                chk("xfer_len", nrise, 16);
                if (exp_cmd_q.size() == 0) begin
                    fail_now("unexpected_xfer");
                end else begin
                    exp_w = exp_cmd_q.pop_front();
                    chk("mosi_cmd", mosi_w, exp_w);
                end
                if (mosi_w == 16'hAD00) last_ah_cyc = cyc;
                $display("spi xfer: mosi=0x%04h miso=0x%04h cyc=%0d", mosi_w, miso_w, cyc);
            end
            prev_ss   = bus.SS_n;
            prev_sclk = bus.SCLK;
        end
    end

    // Output monitor: vld pops the scoreboard, otherwise outputs must hold
    initial begin
        logic        prev_vld = 1'b0;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (bus.vld) begin
                chk("vld_width", prev_vld, 1'b0);
                chk("vld_latency", ((cyc - last_ah_cyc) <= 3), 1'b1);
                if (exp_out_q.size() == 0) begin
                    fail_now("unexpected_vld");
                end else begin
                    e = exp_out_q.pop_front();
                    chk("ptch_rt", bus.ptch_rt, e[31:16]);
                    chk("AZ", bus.AZ, e[15:0]);
                    last_pt = e[31:16];
                    last_az = e[15:0];
                end
                $display("vld: ptch_rt=0x%04h AZ=0x%04h cyc=%0d", bus.ptch_rt, bus.AZ, cyc);
            end else begin
                chk("ptch_hold", bus.ptch_rt, last_pt);
                chk("az_hold", bus.AZ, last_az);
            end
            prev_vld = bus.vld;
        end
    end

    initial begin
        int s0;
        bus.INT = 1'b0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_SS_n", bus.SS_n, 1'b1);
        chk("rst_SCLK", bus.SCLK, 1'b1);
        chk("rst_MOSI", bus.MOSI, 1'b0);
        chk("rst_vld", bus.vld, 1'b0);
        chk("rst_ptch_rt", bus.ptch_rt, 16'h0000);
        chk("rst_AZ", bus.AZ, 16'h0000);

        push_init();
        @(negedge clk);
        rst_n = 1'b1;
        wait_first_ss("pwr_wait");
        wait_drain("init_drain", 3000);
        repeat (300) @(negedge clk);
        chk("idle_SS_n", bus.SS_n, 1'b1);
        chk("init_xfers", xfer_starts, 4);

        push_seq(8'h34, 8'h12, 8'hCD, 8'hAB);
        int_pulse(1);
        wait_drain("seq_fixed", 2500);

        for (int i = 0; i < 6; i++) begin
            push_rand_seq();
            int_pulse($urandom_range(1, 60));
            wait_drain("seq_rand", 2500);
        end

        s0 = xfer_starts;
        for (int k = 0; k < 3; k++) push_rand_seq();
        bus.INT = 1'b1;
        wait_starts("held_start", s0 + 9, 5000);
        bus.INT = 1'b0;
        wait_drain("held_drain", 3000);
        chk("held_xfers", xfer_starts - s0, 12);

        push_rand_seq();
        s0 = xfer_starts;
        int_pulse(2);
        wait_starts("ph_start", s0 + 2, 1000);
        repeat ($urandom_range(10, 200)) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_cmd_q.delete();
        resp_q.delete();
        exp_out_q.delete();
        last_pt = '0;
        last_az = '0;
        #1;
        chk("abort_SS_n", bus.SS_n, 1'b1);
        chk("abort_SCLK", bus.SCLK, 1'b1);
        chk("abort_vld", bus.vld, 1'b0);
        chk("abort_ptch_rt", bus.ptch_rt, 16'h0000);
        chk("abort_AZ", bus.AZ, 16'h0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        push_init();
        s0 = xfer_starts;
        rst_n = 1'b1;
        wait_first_ss("pwr_wait_again");
        wait_drain("reinit_drain", 3000);
        chk("reinit_xfers", xfer_starts - s0, 4);

        push_rand_seq();
        int_pulse($urandom_range(1, 10));
        wait_drain("seq_after_reset", 2500);

        repeat (20) @(negedge clk);
        chk("cmd_q_empty", exp_cmd_q.size(), 0);
        chk("resp_q_empty", resp_q.size(), 0);
        chk("out_q_empty", exp_out_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inert_intf.md
INERT_INTF -- requirements
Module: inert_intf

Interface
REQ-001 Parameter SCLK_DIV_W, default 4: SCLK period = 2^SCLK_DIV_W clk cycles.
REQ-002 clk  input  1  system clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 INT  input  1  sensor data-ready, asynchronous, active-high.
REQ-005 MISO  input  1  SPI serial data from sensor.
REQ-006 SS_n  output  1  SPI slave select, active-low.
REQ-007 SCLK  output  1  SPI clock; idle high.
REQ-008 MOSI  output  1  SPI serial data to sensor.
REQ-009 vld  output  1  one-clk pulse: new ptch_rt/AZ pair available.
REQ-010 ptch_rt  output  16  signed pitch rate, {high byte, low byte}.
REQ-011 AZ  output  16  Z acceleration, {high byte, low byte}.

Function
REQ-012 SHALL contain an SPI master performing 16-bit, MSB-first, mode-3 transfers (MOSI changes on SCLK fall, MISO sampled on SCLK rise).
REQ-013 Transfer: SS_n falls, 16 SCLK periods, SS_n rises half an SCLK period after the last rise; done pulses 1 clk with SS_n rise; rd_data[7:0] = last 8 bits shifted in.
REQ-014 Master SHALL ignore a new wrt while a transfer is in progress.
REQ-015 Power-up wait: a 16-bit counter counts from 0 after reset; init starts on the cycle it reaches all-ones.
REQ-016 Init writes, in order, each started after the previous done: 0x0D02 (INT on data-ready), 0x1053 (accel 208 Hz), 0x1150 (gyro 208 Hz), 0x1460 (rounding).
REQ-017 INT SHALL pass through a 2-flop synchronizer before use; only the synchronized level is acted on.
REQ-018 FSM states: WAIT_PWR, INIT1..INIT4, IDLE, RD_PL, RD_PH, RD_AL, RD_AH, DONE.
REQ-019 IDLE -> RD_PL when synchronized INT is high; otherwise remain in IDLE.
REQ-020 Read commands: RD_PL 0xA200, RD_PH 0xA300, RD_AL 0xAC00, RD_AH 0xAD00; each state waits for done, captures rd_data[7:0] into its byte holding register, then advances.
REQ-021 DONE: vld high for exactly one clk; ptch_rt and AZ update from the holding registers on that same edge; next state IDLE.
REQ-022 ptch_rt and AZ SHALL remain constant between vld pulses; a partial read never changes them.
REQ-023 INT still high on return to IDLE SHALL start a new read sequence immediately; INT edges during a read sequence are not queued.
REQ-024 Latency: vld at most 3 clk after the fourth read's done.

Reset
REQ-025 Reset value of outputs: SS_n=1, SCLK=1, MOSI=0, vld=0, ptch_rt=0, AZ=0; FSM=WAIT_PWR; counter, synchronizer, and holding registers = 0.
REQ-026 Reset mid-transfer SHALL abort the transfer immediately (SS_n high asynchronously) and restart the power-up wait and full init.

Configuration
REQ-027 Macro INERT_FAST_SIM_EN defined: power-up counter is 4 bits (init starts 15 clk after reset release).
REQ-028 INERT_FAST_SIM_EN undefined: 16-bit counter per REQ-015; no other behaviour differs.

Structure
REQ-029 Shared package inert_pkg: FSM state enum, 16-bit init and read command constants.
REQ-030 Sub-module spi_mnrch: SPI master (wrt, cmd[15:0], done, rd_data[15:0], SS_n, SCLK, MOSI, MISO); inert_intf contains only the FSM, timer, synchronizer, and registers.

Verification
REQ-031 Reset, no INT -> exactly 4 SPI transfers with MOSI words 0x0D02, 0x1053, 0x1150, 0x1460, then SS_n held high.
REQ-032 Sensor model returns 0x34, 0x12, 0xCD, 0xAB on one INT -> single vld pulse, ptch_rt=0x1234, AZ=0xABCD.
REQ-033 INT held high -> back-to-back sequences, one vld per 4 reads; outputs update only on vld.
REQ-034 rst_n low during RD_PH transfer -> SS_n=1 immediately; ptch_rt/AZ=0; after release the init sequence repeats.
REQ-035 INT pulse 1 clk wide, asynchronous to clk -> exactly one read sequence and one vld.
REQ-036 INERT_FAST_SIM_EN defined -> first SS_n fall within 20 clk of reset release.
